// File: rtl/shift_reg_pkg.sv
// Definitions shared by the serial shift-link blocks (SIPO receiver and PISO shifter):
// the output-state encoding and the width helper used for bit counters.
package shift_reg_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Ceiling log2 with a floor of 1, so a 2-bit word still gets a 1-bit counter.
  function automatic int clog2(input int unsigned value);
    int unsigned w;
    w = 32'd1;
    while ((32'd1 << w) < value) begin
      w = w + 32'd1;
    end
    return int'(w);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter of the deserializer: frames incoming bits, applies
// sync restarts and bit order, and flags the cycle in which a word completes.
module sipo_shift_core
  import shift_reg_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_si,
  input  logic          i_shift_en,
  input  logic          i_sync,
  output logic          o_word_done,
  output logic [N-1:0]  o_word,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic [N-1:0]  r_sr;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  w_sr_base;
  logic [N-1:0]  w_sr_next;
  logic [CW-1:0] w_cnt_base;
  logic [CW-1:0] w_cnt_next;
  logic          w_done;

  // Next shift/count state; sync clears the frame first so a same-cycle bit starts a new one.
  always_comb begin
    w_sr_base  = r_sr;
    w_cnt_base = r_cnt;
    w_sr_next  = r_sr;
    w_cnt_next = r_cnt;
    w_done     = 1'b0;
    if (i_sync) begin
      w_sr_base  = '0;
      w_cnt_base = '0;
    end else begin
      w_sr_base  = r_sr;
      w_cnt_base = r_cnt;
    end
    if (i_shift_en) begin
      if (MSB_FIRST) begin
        w_sr_next = {w_sr_base[N-2:0], i_si};
      end else begin
        w_sr_next = {i_si, w_sr_base[N-1:1]};
      end
      if (w_cnt_base == LAST_CNT) begin
        w_done     = 1'b1;
        w_cnt_next = '0;
      end else begin
        w_done     = 1'b0;
        w_cnt_next = w_cnt_base + CW'(1);
      end
    end else begin
      w_sr_next  = w_sr_base;
      w_cnt_next = w_cnt_base;
      w_done     = 1'b0;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= w_sr_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign o_word_done = w_done;
  assign o_word      = w_sr_next;
  assign o_cnt       = r_cnt;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: reassembles N-bit words and hands them to a
// parallel consumer over valid/ready, with a sticky overrun flag for dropped words.
module sipo_deserializer
  import shift_reg_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SI,
  input  logic                  shift_en,
  input  logic                  sync,
  output logic [N-1:0]          P,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun,
  input  logic                  clr_ovr,
  output logic [clog2(N)-1:0]   bit_cnt
);

  localparam int CW = clog2(N);

  out_state_e    r_state;
  out_state_e    w_state_next;
  logic [N-1:0]  r_p;
  logic [N-1:0]  w_p_next;
  logic          r_ovr;
  logic          w_ovr_next;
  logic          w_word_done;
  logic [N-1:0]  w_word;
  logic [CW-1:0] w_cnt;
  logic          w_accept;
  logic          w_drop;

  sipo_shift_core #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_si        (SI),
    .i_shift_en  (shift_en),
    .i_sync      (sync),
    .o_word_done (w_word_done),
    .o_word      (w_word),
    .o_cnt       (w_cnt)
  );

  assign w_accept = (r_state == ST_FULL) && ready;

  // Output-state transitions, word delivery and overrun; a drop wins over a clear.
  always_comb begin
    w_state_next = r_state;
    w_p_next     = r_p;
    w_drop       = 1'b0;
    w_ovr_next   = r_ovr;
    case (r_state)
      ST_EMPTY: begin
        if (w_word_done) begin
          w_state_next = ST_FULL;
          w_p_next     = w_word;
        end else begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_word_done) begin
          w_state_next = ST_FULL;
          if (w_accept) begin
            w_p_next = w_word;
          end else begin
            w_drop = 1'b1;
          end
        end else if (w_accept) begin
          w_state_next = ST_EMPTY;
        end else begin
          w_state_next = ST_FULL;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
    if (w_drop) begin
      w_ovr_next = 1'b1;
    end else if (clr_ovr) begin
      w_ovr_next = 1'b0;
    end else begin
      w_ovr_next = r_ovr;
    end
  end

  // Output state, held word and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_p     <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_p     <= w_p_next;
      r_ovr   <= w_ovr_next;
    end
  end

  assign P       = r_p;
  assign valid   = (r_state == ST_FULL);
  assign overrun = r_ovr;
  assign bit_cnt = w_cnt;

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receiver that reassembles N-bit words from a single-bit serial stream, the receive-side counterpart of the team's parallel-in, serial-out shifter. It samples one bit per enabled clock, counts bits to frame boundaries, and presents each completed word on a held parallel output with a valid/ready handshake. Overrun is flagged when a word completes while the previous word is still unconsumed. It sits at the receive end of the on-board serial shift links, feeding parallel consumers.

## Interface
- `N`, 4: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 = first received bit lands in `P[N-1]`; 0 = first bit lands in `P[0]`.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `SI`  in  1  serial data; sampled only when `shift_en`=1.
- `shift_en`  in  1  bit strobe; one bit is consumed per cycle it is high.
- `sync`  in  1  frame restart; discards any partial word.
- `P`  out  N  last completed word; held stable while `valid`=1.
- `valid`  out  1  `P` holds an unconsumed word.
- `ready`  in  1  consumer accepts `P` on a cycle where `valid` & `ready`.
- `overrun`  out  1  sticky: a completed word was dropped.
- `clr_ovr`  in  1  synchronous clear of `overrun`.
- `bit_cnt`  out  clog2(N)  bits received in the current partial word.

## Operation
- Internal state:
  - shift register `sr[N-1:0]`;
  - bit counter `cnt` (0..N-1);
  - output state `EMPTY`/`FULL`, where `valid` = (state == `FULL`).
- Shift, when `shift_en`=1:
  - `MSB_FIRST`=1: `sr <= {sr[N-2:0], SI}`.
  - `MSB_FIRST`=0: `sr <= {SI, sr[N-1:1]}`.
  - `cnt` increments.
- Word completion: `shift_en`=1 and `cnt`=N-1.
  - The completed word is the post-shift value of `sr`.
  - `cnt` wraps to 0.
- Delivery of a completed word:
  - If state is `EMPTY`, or `valid`&`ready` in the same cycle: `P` <= completed word, state `FULL`.
  - Otherwise the word is dropped, `P` is unchanged, `overrun` <= 1, and state stays `FULL`.
- Consumption: `valid`&`ready` with no word completing gives `FULL` -> `EMPTY`. `P` keeps its value and is don't-care to consumers.
- `sync`=1:
  - `cnt` <= 0 and `sr` <= 0; the partial word is lost and no overrun is recorded.
  - If `shift_en`=1 in the same cycle, `SI` becomes bit 0 of the new frame and `cnt` <= 1.
  - `sync` never affects `P`, `valid` or `overrun`.
- `overrun`:
  - Set by a dropped word.
  - Cleared by `clr_ovr`.
  - Set takes priority when set and clear coincide.
- `ready` is ignored while `valid`=0.
- `SI` is ignored while `shift_en`=0.

## Timing
- Reset values: `P`=0, `valid`=0, `overrun`=0, `bit_cnt`=0, `sr`=0, state `EMPTY`.
- Asserting `reset` forces these immediately, independent of `clk`, including mid-word and while `FULL`.
- Release of `reset` is synchronous to `clk`. The first bit is accepted on the first rising edge with `reset`=0 and `shift_en`=1.
- Latency:
  - `valid` rises one cycle after the edge that samples the Nth bit; `P` is valid in that same cycle.
  - Back-to-back words are supported at one bit per cycle.
- Throughput: full rate with `ready` tied high.
  - With `ready`=1 in the completion cycle, the old word is consumed and the new word is loaded on the same edge; `valid` stays 1.
- `valid` never deasserts without a handshake or a reset.
- `bit_cnt` reflects `cnt` registered, i.e. the count after the most recent edge.

## Structure
- Shared package `shift_reg_pkg` holds:
  - the output-state encodings (`ST_EMPTY`=1'b0, `ST_FULL`=1'b1);
  - the `clog2` width function used for `bit_cnt`.
  - The parallel-in/serial-out shifter and this block share it.
- Sub-module `sipo_shift_core` contains `sr`, `cnt`, the `sync` handling and the `MSB_FIRST` direction. It outputs `word_done` and `word`.
- The top level holds the `EMPTY`/`FULL` register, `P`, and the `overrun` logic.

## Test plan
- Reset mid-word:
  - Stimulus: shift in 2 bits, then assert `reset` between clock edges.
  - Response: `bit_cnt`=0, `valid`=0 and `P`=0 immediately.
  - A following 4 bits 1,0,1,0 give `P`=4'b1010 and `valid`=1 one cycle after the 4th bit.
- Bit order, N=4:
  - Stimulus: `MSB_FIRST`=1, send 1,1,0,0 with `ready`=1.
  - Response: `P`=4'b1100.
  - With `MSB_FIRST`=0 the same stream gives `P`=4'b0011.
- Back-to-back words:
  - Stimulus: `ready`=1, `shift_en` held high for 8 cycles, stream 1010 then 1111.
  - Response: `P`=1010 then `P`=1111 on consecutive frame boundaries; `valid` stays 1 and `overrun` stays 0.
- Overrun:
  - Stimulus: `ready`=0, send 1010 then 0110.
  - Response: `P` stays 1010 and `overrun`=1 after the 8th bit.
  - `clr_ovr` pulse clears `overrun`; then `ready`=1 consumes 1010 and `valid` goes to 0.
- Sync:
  - Stimulus: send 1,1, then assert `sync` together with `shift_en` and `SI`=0, then send 1,1,1.
  - Response: `P`=4'b0111 and `overrun`=0.
- Handshake hold:
  - Stimulus: `valid`=1 with `ready`=0 for 5 cycles and no bits sent.
  - Response: `P` and `valid` stay stable; one cycle of `ready`=1 drops `valid` on the next edge.
